// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : btn_conditioner
//  Purpose  : Input stage for the Zombie whack game. Synchronises and
//             debounces three raw asynchronous push-buttons, then emits
//             registered one-cycle press pulses and debounced levels.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEBOUNCE_CYCLES : consecutive cycles a synchronised input must differ
//                      from the debounced level before the level flips
//                      (1 .. 2^24-1)
//    SYNC_STAGES     : flip-flops per input synchroniser (2 .. 4)
//  Ports
//    clk          in   system clock, rising edge
//    rst          in   asynchronous active-high reset
//    btn1..btn3   in   raw active-high buttons, asynchronous to clk
//    btn_level    out  [3:1] debounced level per button
//    btn_press    out  [3:1] one-cycle pulse on a debounced 0->1 edge
//    press_valid  out  high whenever btn_press is nonzero
//    press_id     out  [1:0] lowest pressed button index, 0 when idle
//  Build option
//    BTN_LOCKOUT_EN  : when defined, after any press pulse all further
//                      pulses are suppressed until every button has been
//                      released (debounced level 3'b000).
// ============================================================================
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn1,
    input  logic       btn2,
    input  logic       btn3,
    output logic [3:1] btn_level,
    output logic [3:1] btn_press,
    output logic       press_valid,
    output logic [1:0] press_id
);

    localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0] w_raw;
    logic [2:0] w_flip;       // level toggles at this edge
    logic [2:0] w_rise;       // debounced 0->1 transition at this edge
    logic [2:0] w_issue;      // pulses actually emitted at this edge
    logic [1:0] w_id;

    logic [2:0] r_level;
    logic [2:0] r_press;
    logic       r_valid;
    logic [1:0] r_id;

    assign w_raw = {btn3, btn2, btn1};

    // ------------------------------------------------------------------
    // Per-button synchroniser and debounce counter
    // ------------------------------------------------------------------
    for (genvar i = 0; i < 3; i++) begin : g_btn
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   w_sync;
        logic                   w_differs;

        assign w_sync    = r_sync[SYNC_STAGES-1];
        assign w_differs = (w_sync != r_level[i]);
        assign w_flip[i] = w_differs && (r_cnt == CNT_MAX);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
                // Any cycle of agreement restarts the qualification window,
                // so glitches shorter than the window leave no trace.
                if (!w_differs || (r_cnt == CNT_MAX)) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_rise = w_flip & ~r_level;

    // ------------------------------------------------------------------
    // Optional press lockout
    // ------------------------------------------------------------------
`ifdef BTN_LOCKOUT_EN
    logic r_lockout;

    assign w_issue = r_lockout ? 3'b000 : w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lockout <= 1'b0;
        end else if (r_lockout && (r_level == 3'b000)) begin
            // Released only once every button reads debounced-low.
            r_lockout <= 1'b0;
        end else if (|w_issue) begin
            r_lockout <= 1'b1;
        end
    end
`else
    assign w_issue = w_rise;
`endif

    // Lowest button index wins when several pulse together.
    always_comb begin
        w_id = 2'd0;
        if (w_issue[0]) begin
            w_id = 2'd1;
        end else if (w_issue[1]) begin
            w_id = 2'd2;
        end else if (w_issue[2]) begin
            w_id = 2'd3;
        end
    end

    // ------------------------------------------------------------------
    // Registered levels and pulse outputs, all updated on the same edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= 3'b000;
            r_press <= 3'b000;
            r_valid <= 1'b0;
            r_id    <= 2'd0;
        end else begin
            r_level <= r_level ^ w_flip;
            r_press <= w_issue;
            r_valid <= |w_issue;
            r_id    <= w_id;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign press_valid = r_valid;
    assign press_id    = r_id;

endmodule
`default_nettype wire

// File: doc/btn_conditioner.md
# btn_conditioner

Input stage for the Zombie whack game: takes the three raw, asynchronous push-button inputs, synchronises and debounces them, and emits clean one-cycle press pulses plus debounced levels. The game/LED controller directly downstream consumes `btn_press`/`press_id` instead of raw `btn1..btn3`, so every physical press counts as exactly one hit.

## Interface
- `DEBOUNCE_CYCLES`, 250000, consecutive cycles a synchronised input must differ from the debounced level before the level flips (5 ms at 50 MHz); legal range 1..2^24-1.
- `SYNC_STAGES`, 2, flip-flops in each input synchroniser; legal range 2..4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn1`  in  1  raw button 1, asynchronous to `clk`, active-high.
- `btn2`  in  1  raw button 2, same as `btn1`.
- `btn3`  in  1  raw button 3, same as `btn1`.
- `btn_level`  out  [3:1]  debounced level of each button.
- `btn_press`  out  [3:1]  one-cycle pulse per button on a debounced 0->1 transition.
- `press_valid`  out  1  high in any cycle where `btn_press` is nonzero.
- `press_id`  out  [1:0]  index of pressed button (1, 2, 3); 0 when `press_valid` low.

## Operation
- Per button: `SYNC_STAGES`-deep synchroniser, debounced level register, counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
- Each cycle: if synchronised value equals `btn_level[i]`, counter clears to 0. If it differs and counter == `DEBOUNCE_CYCLES`-1, `btn_level[i]` takes the synchronised value and counter clears; otherwise counter increments. Counter never exceeds `DEBOUNCE_CYCLES`-1; no wrap.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles clears the counter and changes nothing.
- `btn_press[i]` is registered: high for exactly one cycle, the same cycle `btn_level[i]` first reads 1. Releases (1->0) produce no pulse.
- Simultaneous pulses on several buttons: all set in `btn_press`; `press_id` reports the lowest index (btn1 > btn2 > btn3).
- `press_valid`, `press_id` are registered alongside `btn_press` (same cycle).
- Reset: every synchroniser flop, level, counter, and pulse output clears to 0 (`btn_level`=0, `btn_press`=0, `press_valid`=0, `press_id`=0). A button held through reset deassertion is debounced afresh and produces one press pulse after the normal latency.

## Timing
- Raw input first sampled high at edge k (stable before): `btn_level[i]` and `btn_press[i]` are high after edge k + `SYNC_STAGES` - 1 + `DEBOUNCE_CYCLES`. Default parameters: k + 250001.
- Release latency is identical; `btn_level[i]` falls at the same offset after the release edge.
- Pulse width always exactly one cycle regardless of hold time.
- No handshake: downstream samples `press_valid` every cycle; pulses are not held.

## Configuration
- `BTN_LOCKOUT_EN` defined: a lockout register (reset 0) is set in the cycle any press pulse is issued; while set, all new press pulses are suppressed (levels still update). Lockout clears the cycle after `btn_level` becomes 3'b000. Pulses in the same cycle that sets lockout are all issued. Gives one hit per hand-on-buttons episode; pressing btn2 while holding btn1 gives no pulse.
- Not defined: no lockout register; each button pulses independently on every debounced rising edge.

## Test plan
- `DEBOUNCE_CYCLES`=4, `SYNC_STAGES`=2: raise `btn1` at edge 10, hold -> `btn_level`=3'b001 and `btn_press`=3'b001, `press_id`=1 after edge 15 only; `btn_press` 0 after edge 16.
- Pulse `btn2` high for 3 cycles, repeat 5 times with 2-cycle gaps -> `btn_level`, `btn_press`, `press_valid` stay 0 throughout.
- Raise `btn2` and `btn3` on the same edge -> one cycle with `btn_press`=3'b110, `press_id`=2, `press_valid`=1.
- Hold `btn3`, assert `rst` for 2 cycles mid-hold -> all outputs 0 immediately; after deassert at edge r, `btn_press`=3'b100 pulse after edge r+5.
- With `BTN_LOCKOUT_EN`: hold `btn1` (pulse), then raise `btn2` -> no second pulse; release both, wait for `btn_level`=0, raise `btn2` -> `press_id`=2 pulse. Without macro: second pulse `press_id`=2 issued while `btn1` held.
